// File: rtl/dmem_access_arbiter_if.sv
// Requester-side bus of the data-memory arbiter. One instance is used for the
// CPU load/store path and one for the debug/loader port.
//
// Handshake: the requester raises req together with we/addr/wdata and keeps
// all four stable until it sees gnt high in the same cycle. Each gnt is one
// completed access. A read returns rdata with rvalid high for exactly one
// cycle, the cycle after its gnt. Dropping req before gnt cancels the request
// and nothing is issued.
//
// Signals:
//   req    requester -> arbiter  access request
//   we     requester -> arbiter  1 = write/store, 0 = read/load
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  access performed this cycle
//   rvalid arbiter -> requester  read data valid (one cycle)
//   rdata  arbiter -> requester  registered read data
interface dmem_access_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [WIDTH-1:0]      rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_access_arbiter.sv
// Shares a single-port data memory (combinational read, clocked write)
// between the CPU load/store path and a debug/loader port. The CPU has
// priority; a debug request denied MAX_WAIT cycles in a row is force-granted
// once. A debug grant taken with dbg_lock = 1 keeps ownership (CPU blocked)
// until dbg_lock or dbg_req drops.
//
// Optional feature: define DMEM_ARB_STATS_EN to add conflict_cnt, a 16-bit
// saturating count of cycles in which both requesters were asking.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   cpu            CPU requester bus (slave side)
//   dbg            debug requester bus (slave side)
//   dbg_lock       hold debug ownership across back-to-back accesses
//   mem_we/addr/wdata  memory write enable, address, write data (0 when idle)
//   mem_rdata      combinational read data from memory
//   fsm_state      1 while the debug port holds the lock
//   conflict_cnt   (DMEM_ARB_STATS_EN only) simultaneous-request cycle count
module dmem_access_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_access_arbiter_if.slave  cpu,
    dmem_access_arbiter_if.slave  dbg,
    input  logic                  dbg_lock,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  fsm_state
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]           conflict_cnt
`endif
);

    typedef enum logic {
        IDLE       = 1'b0,
        DBG_LOCKED = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t          state;
    logic [3:0]      wait_cnt;
    logic            cpu_win;
    logic            dbg_win;
    logic            cpu_rvalid_q;
    logic            dbg_rvalid_q;
    logic [WIDTH-1:0] cpu_rdata_q;
    logic [WIDTH-1:0] dbg_rdata_q;

    // CPU wins unless the debug port owns the memory or has been starved
    // for MAX_WAIT cycles; debug takes every cycle the CPU does not.
    always_comb begin
        cpu_win = (state == IDLE) && cpu.req && (wait_cnt < WAIT_LIMIT);
        dbg_win = dbg.req && !cpu_win;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_win) begin
            mem_we    = cpu.we;
            mem_addr  = cpu.addr;
            mem_wdata = cpu.wdata;
        end else if (dbg_win) begin
            mem_we    = dbg.we;
            mem_addr  = dbg.addr;
            mem_wdata = dbg.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE:       if (dbg_win && dbg_lock) state <= DBG_LOCKED;
                DBG_LOCKED: if (!dbg_lock || !dbg.req) state <= IDLE;
            endcase

            // Counts consecutive denied debug cycles; saturates at the limit.
            if (!dbg.req || dbg_win) begin
                wait_cnt <= '0;
            end else if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            cpu_rvalid_q <= cpu_win && !cpu.we;
            dbg_rvalid_q <= dbg_win && !dbg.we;
            if (cpu_win && !cpu.we) cpu_rdata_q <= mem_rdata;
            if (dbg_win && !dbg.we) dbg_rdata_q <= mem_rdata;
        end
    end

    assign cpu.gnt    = cpu_win;
    assign dbg.gnt    = dbg_win;
    assign cpu.rvalid = cpu_rvalid_q;
    assign dbg.rvalid = dbg_rvalid_q;
    assign cpu.rdata  = cpu_rdata_q;
    assign dbg.rdata  = dbg_rdata_q;
    assign fsm_state  = (state == DBG_LOCKED);

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (cpu.req && dbg.req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_dmem_access_arbiter;

    localparam int WIDTH      = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int MAX_WAIT   = 4;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    dmem_access_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) cpu_if ();
    dmem_access_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dbg_if ();
    logic                  dbg_lock;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  fsm_state;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]           conflict_cnt;
`endif

    dmem_access_arbiter #(
        .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu       (cpu_if.slave),
        .dbg       (dbg_if.slave),
        .dbg_lock  (dbg_lock),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .fsm_state (fsm_state)
`ifdef DMEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Data memory: combinational read, clocked write.
    logic [WIDTH-1:0] mem [DEPTH];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int  denied_run;    // consecutive cycles debug asked and was refused
    bit  dbg_owns;      // debug holds the memory through a lock
    int  conflicts;     // cycles with both requesters asking
    bit  seen_cpu_gnt;
    bit  seen_dbg_gnt;

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] cpu_exp_q [$];
    logic [WIDTH-1:0] dbg_exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever a requester sees rvalid, the oldest expected read
    // data must be waiting for it; an expected read without rvalid is a miss.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_if.rvalid) begin
                if (cpu_exp_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else check("cpu_rdata", cpu_if.rdata, cpu_exp_q.pop_front());
            end else if (cpu_exp_q.size() != 0) begin
                check("cpu_rvalid_missing", 32'd0, 32'd1);
                void'(cpu_exp_q.pop_front());
            end
            if (dbg_if.rvalid) begin
                if (dbg_exp_q.size() == 0) check("dbg_rvalid_unexpected", 32'd1, 32'd0);
                else check("dbg_rdata", dbg_if.rdata, dbg_exp_q.pop_front());
            end else if (dbg_exp_q.size() != 0) begin
                check("dbg_rvalid_missing", 32'd0, 32'd1);
                void'(dbg_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One cycle: apply inputs at negedge, check grants and memory bus, then
    // advance the model at the following posedge.
    task automatic drive(input bit c_req, input bit c_we, input logic [ADDR_WIDTH-1:0] c_addr,
                         input logic [WIDTH-1:0] c_wdata,
                         input bit d_req, input bit d_we, input logic [ADDR_WIDTH-1:0] d_addr,
                         input logic [WIDTH-1:0] d_wdata, input bit d_lock);
        bit                    ec;
        bit                    ed;
        bit                    e_we;
        logic [ADDR_WIDTH-1:0] e_addr;
        logic [WIDTH-1:0]      e_wdata;
        @(negedge clk);
        cpu_if.req = c_req; cpu_if.we = c_we; cpu_if.addr = c_addr; cpu_if.wdata = c_wdata;
        dbg_if.req = d_req; dbg_if.we = d_we; dbg_if.addr = d_addr; dbg_if.wdata = d_wdata;
        dbg_lock = d_lock;
        #1;
        ec = c_req && !dbg_owns && (denied_run < MAX_WAIT);
        ed = d_req && !ec;
        e_we = 1'b0; e_addr = '0; e_wdata = '0;
        if (ec) begin
            e_we = c_we; e_addr = c_addr; e_wdata = c_wdata;
        end else if (ed) begin
            e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        end
        seen_cpu_gnt = cpu_if.gnt;
        seen_dbg_gnt = dbg_if.gnt;
        check("cpu_gnt", 32'(cpu_if.gnt), 32'(ec));
        check("dbg_gnt", 32'(dbg_if.gnt), 32'(ed));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", mem_wdata, e_wdata);
        check("fsm_state", 32'(fsm_state), 32'(dbg_owns));
`ifdef DMEM_ARB_STATS_EN
        check("conflict_cnt", 32'(conflict_cnt), 32'(conflicts));
`endif
        @(posedge clk);
        if (ec && !c_we) cpu_exp_q.push_back(ref_mem[c_addr]);
        if (ec && c_we) ref_mem[c_addr] = c_wdata;
        if (ed && !d_we) dbg_exp_q.push_back(ref_mem[d_addr]);
        if (ed && d_we) ref_mem[d_addr] = d_wdata;
        if (d_req && !ed) denied_run = (denied_run < MAX_WAIT) ? denied_run + 1 : MAX_WAIT;
        else denied_run = 0;
        dbg_owns = ed && d_lock;
        if (c_req && d_req && conflicts < 65535) conflicts++;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // Called right after rst_n falls: checks reset values at once, then
    // holds reset for two cycles.
    task automatic hold_reset(input string tag);
        cpu_exp_q.delete();
        dbg_exp_q.delete();
        denied_run = 0;
        dbg_owns   = 1'b0;
        conflicts  = 0;
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
        dbg_if.req = 1'b0; dbg_if.we = 1'b0; dbg_if.addr = '0; dbg_if.wdata = '0;
        dbg_lock = 1'b0;
        #1;
        check({tag, "_cpu_rvalid"}, 32'(cpu_if.rvalid), 32'd0);
        check({tag, "_dbg_rvalid"}, 32'(dbg_if.rvalid), 32'd0);
        check({tag, "_cpu_rdata"}, cpu_if.rdata, 32'd0);
        check({tag, "_dbg_rdata"}, dbg_if.rdata, 32'd0);
        check({tag, "_fsm_state"}, 32'(fsm_state), 32'd0);
`ifdef DMEM_ARB_STATS_EN
        check({tag, "_conflict_cnt"}, 32'(conflict_cnt), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        hold_reset(tag);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [9:0]            pat;
        bit                    cp, dp, cwe, dwe, dlk;
        logic [ADDR_WIDTH-1:0] caddr, daddr;
        logic [WIDTH-1:0]      cwd, dwd;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     <= WIDTH'(32'hA5A50000 + i);
            ref_mem[i]  = WIDTH'(32'hA5A50000 + i);
        end
        #2;
        reset_now("reset");

        // CPU store then load of the same word.
        drive(1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #1;
        check("t1_cpu_rvalid", 32'(cpu_if.rvalid), 32'd1);
        check("t1_cpu_rdata", cpu_if.rdata, 32'hDEADBEEF);
        check("t1_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);
        idle();

        // Both requesters held: four CPU grants, one forced debug grant.
        @(negedge clk);
        reset_now("t2_reset");
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 5'd1, '0, 1'b1, 1'b0, 5'd2, '0, 1'b0);
            pat = {pat[8:0], seen_cpu_gnt};
        end
        check("t2_cpu_gnt_pattern", 32'(pat), 32'(10'b1111011110));
        idle();
        idle();
`ifdef DMEM_ARB_STATS_EN
        #1;
        check("t6_conflict_cnt_hold", 32'(conflict_cnt), 32'd10);
`endif

        // Locked debug write/read with the CPU waiting.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 5'd7, 32'h12345678, 1'b1);
        drive(1'b1, 1'b0, 5'd5, '0, 1'b1, 1'b0, 5'd7, '0, 1'b1);
        check("t3_cpu_blocked_a", 32'(seen_cpu_gnt), 32'd0);
        #1;
        check("t3_dbg_rvalid", 32'(dbg_if.rvalid), 32'd1);
        check("t3_dbg_rdata", dbg_if.rdata, 32'h12345678);
        drive(1'b1, 1'b0, 5'd5, '0, 1'b1, 1'b0, 5'd7, '0, 1'b0);
        check("t3_cpu_blocked_b", 32'(seen_cpu_gnt), 32'd0);
        drive(1'b1, 1'b0, 5'd5, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check("t3_cpu_after_unlock", 32'(seen_cpu_gnt), 32'd1);
        idle();

        // Reset in the cycle after a granted read.
        drive(1'b1, 1'b0, 5'd3, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #2;
        reset_now("t4_cpu");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 5'd7, '0, 1'b1);
        #1;
        check("t4_locked_before", 32'(fsm_state), 32'd1);
        #1;
        reset_now("t4_dbg");

        // No requests.
        repeat (3) idle();
        #1;
        check("t5_cpu_rvalid", 32'(cpu_if.rvalid), 32'd0);
        check("t5_dbg_rvalid", 32'(dbg_if.rvalid), 32'd0);

        // Random traffic; requests are held until granted or abandoned.
        cp = 0; dp = 0; cwe = 0; dwe = 0; dlk = 0;
        caddr = '0; daddr = '0; cwd = '0; dwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!cp && $urandom_range(0, 9) < 6) begin
                cp = 1; cwe = 1'($urandom_range(0, 1));
                caddr = ADDR_WIDTH'($urandom_range(0, DEPTH - 1)); cwd = $urandom;
            end else if (cp && $urandom_range(0, 19) == 0) begin
                cp = 0;
            end
            if (!dp && $urandom_range(0, 9) < 5) begin
                dp = 1; dwe = 1'($urandom_range(0, 1));
                daddr = ADDR_WIDTH'($urandom_range(0, DEPTH - 1)); dwd = $urandom;
                dlk = ($urandom_range(0, 2) == 0);
            end else if (dp && $urandom_range(0, 19) == 0) begin
                dp = 0;
            end
            drive(cp, cwe, caddr, cwd, dp, dwe, daddr, dwd, dlk);
            if (seen_cpu_gnt) cp = 0;
            if (seen_dbg_gnt) dp = 0;
        end
        idle();
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
